// File: rtl/mux_scan.sv
// Registered N_CH x DATA_W mux with manual select or round-robin scan (DWELL cycles per channel).
// Latency 1 cycle for all outputs; no backpressure, a new value is presented every cycle.
module mux_scan #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8,
  parameter int DWELL  = 3,
  localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_mode,
  input  logic [SEL_W-1:0]         i_sel,
  input  logic                     i_hold,
  input  logic [N_CH*DATA_W-1:0]   i_data,
  output logic [DATA_W-1:0]        o_data,
  output logic [SEL_W-1:0]         o_ch,
  output logic                     o_valid,
  output logic                     o_err,
  output logic                     o_wrap
);

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] LAST_CH    = SEL_W'(N_CH - 1);
  localparam logic [SEL_W:0]   NCH        = (SEL_W + 1)'(N_CH);

  typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

  state_t            state;
  state_t            nxt_state;
  logic [SEL_W-1:0]  scan_ch;
  logic [SEL_W-1:0]  nxt_ch;
  logic [DW_W-1:0]   dwell_cnt;
  logic [DW_W-1:0]   nxt_dwell;
  logic              entering_scan;
  logic              step;
  logic              sel_ok;
  logic [DATA_W-1:0] ch [N_CH];

  for (genvar k = 0; k < N_CH; k++) begin : g_unpack
    assign ch[k] = i_data[k*DATA_W +: DATA_W];
  end

  // Outputs show the post-edge scan channel, so the entry edge is the first dwell cycle of ch0.
  always_comb begin
    nxt_state     = i_mode ? SCAN : MANUAL;
    entering_scan = i_mode && (state != SCAN);
    step          = !i_hold && (dwell_cnt == DWELL_LAST);
    sel_ok        = ({1'b0, i_sel} < NCH);
    nxt_ch        = scan_ch;
    nxt_dwell     = dwell_cnt;
    if (entering_scan) begin
      nxt_ch    = '0;
      nxt_dwell = '0;
    end else if (step) begin
      nxt_ch    = (scan_ch == LAST_CH) ? '0 : scan_ch + 1'b1;
      nxt_dwell = '0;
    end else if (!i_hold) begin
      nxt_dwell = dwell_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      scan_ch   <= '0;
      dwell_cnt <= '0;
      o_data    <= '0;
      o_ch      <= '0;
      o_valid   <= 1'b0;
      o_err     <= 1'b0;
      o_wrap    <= 1'b0;
    end else begin
      state   <= nxt_state;
      o_valid <= (nxt_state == state);
      if (i_mode) begin
        scan_ch   <= nxt_ch;
        dwell_cnt <= nxt_dwell;
        o_ch      <= nxt_ch;
        o_data    <= ch[nxt_ch];
        o_err     <= 1'b0;
        o_wrap    <= !entering_scan && step && (scan_ch == LAST_CH);
      end else begin
        o_ch   <= i_sel;
        o_data <= sel_ok ? ch[i_sel] : '0;
        o_err  <= !sel_ok;
        o_wrap <= 1'b0;
      end
    end
  end

endmodule
